// File: rtl/lzw_pkg.sv
// lzw_pkg: shared LZW constants, packer state encoding and a clog2 helper.
// Contents:
//   stateT               RUN / FLUSH / DONE states of the code packer
//   DefCodeW/MinW/OutW   default code and word widths, reused by the controller
//   clog2()              ceiling log2 usable in constant expressions
package lzw_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} stateT;

    localparam int DefCodeW = 12;
    localparam int DefMinW  = 9;
    localparam int DefOutW  = 8;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/lzw_sync_fifo.sv
// lzw_sync_fifo: show-ahead synchronous FIFO with async active-low reset.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, pushData  write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   popData         head word, valid while !empty, zero when empty
//   full, empty     occupancy flags
//   level           current occupancy 0..DEPTH
module lzw_sync_fifo
    import lzw_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            pushData,
    input  logic                        pop,
    output logic [WIDTH-1:0]            popData,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic doPush, doPop;

    always_comb begin
        full    = level == LW'(DEPTH);
        empty   = level == '0;
        doPush  = push && !full;
        doPop   = pop && !empty;
        popData = empty ? '0 : mem[rdPtr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            level <= '0;
        end else begin
            rdPtr <= rdPtr + AW'(doPop);
            wrPtr <= wrPtr + AW'(doPush);
            level <= level + LW'(doPush) - LW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/lzw_code_packer.sv
// lzw_code_packer: packs variable-width LZW codes LSB-first into OUT_W-bit words.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   code_in/width/valid     code beat in; code_ready accepts it
//   close                   end-of-stream request (level)
//   out_data/valid/ready    packed word stream from a DEPTH-entry FIFO
//   fifo_level              FIFO occupancy
//   width_err               sticky illegal-width flag
//   done                    one-cycle pulse once flushed and drained
//   code_count, word_count  present only with LZW_PACKER_STATS_EN defined:
//                           saturating legal-beat and word-pop counters,
//                           cleared after the DONE cycle
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int CODE_W = DefCodeW,
    parameter int MIN_W  = DefMinW,
    parameter int OUT_W  = DefOutW,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CODE_W-1:0]           code_in,
    input  logic [clog2(CODE_W+1)-1:0]  code_width,
    input  logic                        code_valid,
    output logic                        code_ready,
    input  logic                        close,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                        width_err,
    output logic                        done
`ifdef LZW_PACKER_STATS_EN
    ,
    output logic [15:0]                 code_count,
    output logic [15:0]                 word_count
`endif
);
    localparam int ACC_W = CODE_W + OUT_W - 1;
    localparam int CW    = clog2(ACC_W + 1);
    localparam int WW    = clog2(CODE_W + 1);

    stateT state;
    logic [ACC_W-1:0] acc, newBits;
    logic [CW-1:0] accCnt;
    logic [CODE_W-1:0] maskedCode;
    logic live, closeArmed, hasWord, tail, push, accept, legal, full, empty;

    always_comb begin
        hasWord    = accCnt >= CW'(OUT_W);
        // live keeps code_ready low while reset is held and for the first edge after it
        code_ready = live && state == RUN && !hasWord;
        accept     = code_valid && code_ready;
        legal      = code_width >= WW'(MIN_W) && code_width <= WW'(CODE_W);
        maskedCode = code_in & ~({CODE_W{1'b1}} << code_width);
        newBits    = ACC_W'(maskedCode) << accCnt;
        tail       = state == FLUSH && accCnt != '0 && !hasWord;
        push       = (hasWord || tail) && !full;
        out_valid  = !empty;
    end

    // Bits above accCnt are always zero, so the flush remainder is already zero-padded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            acc        <= '0;
            accCnt     <= '0;
            live       <= 1'b0;
            closeArmed <= 1'b1;
            width_err  <= 1'b0;
            done       <= 1'b0;
        end else begin
            live <= 1'b1;
            done <= 1'b0;
            if (accept && legal) begin
                acc    <= acc | newBits;
                accCnt <= accCnt + CW'(code_width);
            end else if (push) begin
                acc    <= acc >> OUT_W;
                accCnt <= hasWord ? accCnt - CW'(OUT_W) : '0;
            end
            if (accept && !legal) width_err <= 1'b1;
            if (state == RUN) begin
                if (!close) closeArmed <= 1'b1;
                else if (closeArmed) state <= FLUSH;
            end else if (state == FLUSH) begin
                if (accCnt == '0 && empty) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
            end else begin
                state      <= RUN;
                acc        <= '0;
                accCnt     <= '0;
                closeArmed <= 1'b0;
            end
        end
    end

`ifdef LZW_PACKER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_count <= '0;
            word_count <= '0;
        end else begin
            code_count <= state == DONE ? '0 : code_count + 16'((accept && legal) && code_count != '1);
            word_count <= state == DONE ? '0 : word_count + 16'((out_valid && out_ready) && word_count != '1);
        end
    end
`endif

    lzw_sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (acc[OUT_W-1:0]),
        .pop      (out_ready),
        .popData  (out_data),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_lzw_code_packer.sv
// tb_lzw_code_packer: scoreboard bench for lzw_code_packer.
module tb_lzw_code_packer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [11:0] code_in = '0;
    logic [3:0] code_width = '0;
    logic code_valid = 1'b0, close = 1'b0, out_ready = 1'b0;
    logic code_ready, out_valid, width_err, done;
    logic [7:0] out_data;
    logic [4:0] fifo_level;
`ifdef LZW_PACKER_STATS_EN
    logic [15:0] code_count, word_count;
    logic checkZero = 1'b0;
`endif

    int checks = 0, failures = 0, doneCount = 0, wordsSeen = 0;
    int expCodes = 0, expWords = 0;
    logic [7:0] expQ[$];
    bit modelBits[$];
    logic [7:0] want;

    lzw_code_packer dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_width (code_width),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .close      (close),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .width_err  (width_err),
        .done       (done)
`ifdef LZW_PACKER_STATS_EN
        ,
        .code_count (code_count),
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: a word is taken at the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (reset) begin
`ifdef LZW_PACKER_STATS_EN
            if (checkZero) begin
                checkZero = 1'b0;
                checks++;
                if (code_count !== 16'd0 || word_count !== 16'd0) begin
                    failures++;
                    $display("FAIL stats_clear code_count=%0d word_count=%0d want 0 0", code_count, word_count);
                end
            end
`endif
            if (out_valid && out_ready) begin
                checks++;
                wordsSeen++;
                expWords++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL word_unexpected got=%h", out_data);
                end else begin
                    want = expQ.pop_front();
                    if (out_data !== want) begin
                        failures++;
                        $display("FAIL word got=%h want=%h", out_data, want);
                    end
                end
            end
            if (done) begin
                doneCount++;
`ifdef LZW_PACKER_STATS_EN
                checks++;
                if (code_count !== 16'(expCodes) || word_count !== 16'(expWords)) begin
                    failures++;
                    $display("FAIL stats_done code_count=%0d word_count=%0d want %0d %0d",
                             code_count, word_count, expCodes, expWords);
                end
                checkZero = 1'b1;
`endif
                expCodes = 0;
                expWords = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic modelPush(input logic [11:0] v, input int w);
        logic [7:0] b;
        if (w >= 9 && w <= 12) begin
            expCodes++;
            for (int i = 0; i < w; i++) modelBits.push_back(v[i]);
            while (modelBits.size() >= 8) begin
                for (int j = 0; j < 8; j++) b[j] = modelBits.pop_front();
                expQ.push_back(b);
            end
        end
    endtask

    task automatic modelFlush();
        logic [7:0] b;
        b = '0;
        if (modelBits.size() > 0) begin
            for (int j = 0; modelBits.size() > 0; j++) b[j] = modelBits.pop_front();
            expQ.push_back(b);
        end
    endtask

    task automatic sendCode(input logic [11:0] v, input int w);
        bit ok;
        ok = 0;
        code_in = v;
        code_width = w[3:0];
        code_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (code_ready) ok = 1;
            tick(1);
        end
        code_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout code_ready=%b want 1", code_ready);
        end else modelPush(v, w);
    endtask

    task automatic waitDone(input int start);
        for (int i = 0; i < 500 && doneCount == start; i++) tick(1);
        checks++;
        if (doneCount == start) begin
            failures++;
            $display("FAIL done_timeout done_count=%0d want %0d", doneCount, start + 1);
        end
    endtask

    task automatic doClose();
        int d0;
        d0 = doneCount;
        modelFlush();
        close = 1'b1;
        waitDone(d0);
        close = 1'b0;
        tick(1);
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if (expQ.size() != 0 || fifo_level !== 5'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle pending=%0d level=%0d valid=%b want 0 0 0", name, expQ.size(), fifo_level, out_valid);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checks++;
        if ({code_ready, out_valid, width_err, done} !== 4'b0 || fifo_level !== 5'd0 || out_data !== 8'd0) begin
            failures++;
            $display("FAIL %s ready=%b valid=%b err=%b done=%b level=%0d data=%h want all 0",
                     name, code_ready, out_valid, width_err, done, fifo_level, out_data);
        end
    endtask

    task automatic test_reset();
        #2;
        checkResetOutputs("reset_init");
        #11 reset = 1'b1;
        tick(2);
        checks++;
        if (code_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b want 1", code_ready);
        end
    endtask

    task automatic test_basic();
        int d0;
        d0 = doneCount;
        out_ready = 1'b1;
        sendCode(12'h101, 9);
        sendCode(12'h0FF, 9);
        doClose();
        tick(5);
        checks++;
        if (doneCount != d0 + 1) begin
            failures++;
            $display("FAIL basic_done_once got=%0d want %0d", doneCount - d0, 1);
        end
        checkIdle("basic");
    endtask

    task automatic test_backpressure();
        int w0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) sendCode(12'hABC, 12);
        tick(3);
        checks++;
        if (code_ready !== 1'b0 || fifo_level !== 5'd16 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full ready=%b level=%0d valid=%b want 0 16 1", code_ready, fifo_level, out_valid);
        end
        w0 = wordsSeen;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && expQ.size() != 0; i++) tick(1);
        tick(2);
        checks++;
        if (wordsSeen - w0 != 18) begin
            failures++;
            $display("FAIL bp_count got=%0d want 18", wordsSeen - w0);
        end
        doClose();
        checkIdle("bp");
    endtask

    task automatic test_width_err();
        out_ready = 1'b1;
        sendCode(12'h155, 9);
        sendCode(12'h07F, 7);
        sendCode(12'h0AA, 9);
        checks++;
        if (width_err !== 1'b1) begin
            failures++;
            $display("FAIL width_err_set got=%b want 1", width_err);
        end
        doClose();
        tick(3);
        checks++;
        if (width_err !== 1'b1) begin
            failures++;
            $display("FAIL width_err_sticky got=%b want 1", width_err);
        end
        checkIdle("width");
    endtask

    task automatic test_empty_close();
        int d0, w0;
        d0 = doneCount;
        w0 = wordsSeen;
        out_ready = 1'b1;
        close = 1'b1;
        waitDone(d0);
        tick(10);
        checks++;
        if (doneCount != d0 + 1 || wordsSeen != w0) begin
            failures++;
            $display("FAIL empty_close_hold dones=%0d words=%0d want 1 0", doneCount - d0, wordsSeen - w0);
        end
        close = 1'b0;
        tick(1);
        close = 1'b1;
        waitDone(d0 + 1);
        close = 1'b0;
        tick(2);
        checks++;
        if (doneCount != d0 + 2) begin
            failures++;
            $display("FAIL empty_close_rearm dones=%0d want 2", doneCount - d0);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        sendCode(12'h1AB, 9);
        sendCode(12'h0CD, 9);
        sendCode(12'h7EF, 11);
        tick(3);
        checks++;
        if (fifo_level !== 5'd3) begin
            failures++;
            $display("FAIL mid_level got=%0d want 3", fifo_level);
        end
        #3 reset = 1'b0;
        #1;
        checkResetOutputs("reset_async");
        expQ.delete();
        modelBits.delete();
        expCodes = 0;
        expWords = 0;
        #3 reset = 1'b1;
        tick(2);
        out_ready = 1'b1;
        sendCode(12'h1FF, 9);
        doClose();
        tick(2);
        checkIdle("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_width_err();
        test_empty_close();
        test_reset_mid();
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lzw_code_packer.md
Name: lzw_code_packer

Overview:
Parametrised successor to the fixed 12-bit output buffer stage of the LZW compressor. It accepts variable-width dictionary codes (runtime width MIN_W..CODE_W) over a valid/ready handshake. Codes are packed LSB-first into OUT_W-bit words, buffered in a DEPTH-entry FIFO, and emitted over a valid/ready handshake. It sits between the controller/Registers code output and the output file writer. A close request flushes the partial word, zero-padded.

Parameters:
CODE_W, 12, maximum code width in bits
MIN_W, 9, minimum legal code width
OUT_W, 8, output word width in bits
DEPTH, 16, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
code_in  in  CODE_W  code value; only the low code_width bits are used
code_width  in  clog2(CODE_W+1)  width of the current code
code_valid  in  1  code beat offered
code_ready  out  1  packer accepts a beat when code_valid && code_ready
close  in  1  end-of-stream request (level, sampled in RUN)
out_data  out  OUT_W  packed word at FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer takes the word when out_valid && out_ready
fifo_level  out  clog2(DEPTH+1)  current FIFO occupancy
width_err  out  1  sticky: an accepted beat had an illegal width
done  out  1  one-cycle pulse: flush complete and FIFO drained

Behaviour:
- Reset (async, reset=0): state=RUN, accumulator and bit count = 0, FIFO empty. All outputs 0: code_ready, out_valid, fifo_level, width_err, done, out_data.
- Accumulator: ACC_W = CODE_W+OUT_W-1 bits; acc_cnt ranges 0..ACC_W.
- code_ready = (state==RUN) && (acc_cnt < OUT_W).
- Accept: new bits are ORed in at bit position acc_cnt, then acc_cnt += w.
- Drain: when acc_cnt >= OUT_W and the FIFO is not full, acc[OUT_W-1:0] is pushed, the accumulator shifts right by OUT_W, and acc_cnt -= OUT_W. At most one push per cycle.
- Accept and drain are mutually exclusive by construction.
- Illegal width (w<MIN_W or w>CODE_W): the beat is consumed but discarded, and width_err sets. width_err clears only on reset.
- FIFO: show-ahead. A word pushed at edge E is on out_data with out_valid=1 immediately after E. Push and pop in the same cycle are allowed when the FIFO is non-empty.
- FIFO full: drain stalls, acc_cnt stays >= OUT_W, and code_ready stays low. Back-pressure propagates with no data loss.
- Latency: code accepted at edge E0 → first resulting word visible after E1 (if the FIFO is not full).
- States:
  - RUN: on close=1 → FLUSH. A beat accepted in the same cycle as close is included in the stream.
  - FLUSH: code_ready=0. Drain full words. When 0 < acc_cnt < OUT_W and the FIFO is not full, push the remainder zero-padded and set acc_cnt=0. When acc_cnt==0 and the FIFO is empty → DONE.
  - DONE: done=1 for one cycle. Accumulator cleared, then → RUN. close is ignored until it has been seen low once after DONE.
- Empty stream: close with acc_cnt==0 and the FIFO empty → FLUSH→DONE with no words emitted.
- Reset mid-operation discards all buffered bits and FIFO contents immediately.

Optional Feature:
Macro LZW_PACKER_STATS_EN.
- Defined: adds outputs code_count[15:0] (accepted legal beats) and word_count[15:0] (FIFO pops). Both are saturating, reset to 0, and clear on the DONE cycle after being sampled in it.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lzw_pkg: state encoding (RUN/FLUSH/DONE), default CODE_W/MIN_W/OUT_W, and a clog2 helper function. The controller reuses the same width constants.
- One sub-module, lzw_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level, show-ahead, async active-low reset). The accumulator and FSM stay in lzw_code_packer.

Test Plan:
1. out_ready=1; codes 0x101 then 0x0FF at width 9; then close → words 0x01, 0xFF, 0x01 (last is 2 bits, zero-padded); done pulses once; fifo_level returns to 0.
2. Twelve 12-bit codes 0xABC with out_ready=0 and DEPTH=16 → code_ready drops once fifo_level=16 with acc_cnt>=8. Raise out_ready → 18 words in repeating pattern 0xBC,0xCA,0xAB; no loss.
3. A code at width 7 between two legal 9-bit codes → width_err=1 and stays set; output equals the stream of the two legal codes only.
4. close with no codes sent → no out_valid, done pulses; holding close high afterwards does not cause a second done until close drops and rises again.
5. Assert reset low mid-stream with 3 words in the FIFO and acc_cnt=5 → all outputs 0 asynchronously; after release, a fresh 9-bit 0x1FF plus close → 0xFF, 0x01.
6. With LZW_PACKER_STATS_EN, scenario 1 → code_count=2 and word_count=3 in the done cycle, then 0.
